// File: rtl/os_result_drain_if.sv
`default_nettype none
// ============================================================================
// Module   : os_result_drain_if
// Purpose  : Bundles the signals between the OS result drain, the top-level
//            controller (select code, data, end-of-output pulse) and the
//            off-chip byte sink (valid/ready/last stream plus status).
// Ports    : slave  - the drain block (consumes select/data, drives stream)
//            master - controller and sink side
// Revision : 1.0 - initial release
// ============================================================================
interface os_result_drain_if #(
    parameter int DATA_W = 16
);
    logic [3:0]        os_sel;
    logic [DATA_W-1:0] os_data;
    logic              end_os;
    logic [7:0]        out_byte;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              overflow;

    modport master (
        output os_sel, os_data, end_os, out_ready,
        input  out_byte, out_valid, out_last, busy, overflow
    );

    modport slave (
        input  os_sel, os_data, end_os, out_ready,
        output out_byte, out_valid, out_last, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/os_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : os_result_drain
// Purpose  : Captures the OS results presented by the shared result mux into
//            a local buffer, then streams them out as bytes, most significant
//            byte of each result first, over a valid/ready handshake.
// Ports    : clk  - system clock, rising edge
//            RST  - asynchronous active-high reset
//            bus  - os_sel/os_data/end_os in, out_byte/out_valid/out_last/
//                   busy/overflow out, out_ready in
// Revision : 1.0 - initial release
// ============================================================================
module os_result_drain #(
    parameter int DATA_W  = 16,
    parameter int NUM_RES = 9
) (
    input  wire logic         clk,
    input  wire logic         RST,
    os_result_drain_if.slave  bus
);
    localparam int c_BPR    = DATA_W / 8;
    localparam int c_TOTAL  = NUM_RES * c_BPR;
    localparam int c_IDX_W  = (c_TOTAL > 1) ? $clog2(c_TOTAL) : 1;
    localparam int c_WORD_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_TOTAL - 1);
    localparam logic [3:0]         c_SEL_MAX  = 4'(NUM_RES);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_SEND    = 2'd2;

    logic [1:0]          r_state,    w_state_nxt;
    logic [NUM_RES-1:0]  r_mask,     w_mask_nxt;
    logic [c_IDX_W-1:0]  r_idx,      w_idx_nxt;
    logic                r_overflow, w_overflow_nxt;
    logic [DATA_W-1:0]   r_buf [NUM_RES];

    logic                w_sel_ok;
    logic [c_WORD_W-1:0] w_wr_idx;
    logic                w_cap;
    logic                w_send;
    logic [c_WORD_W-1:0] w_word_idx;
    logic [DATA_W-1:0]   w_word;

    // Codes above NUM_RES are not results and are dropped silently.
    assign w_sel_ok = (bus.os_sel != 4'd0) && (bus.os_sel <= c_SEL_MAX);
    assign w_wr_idx = c_WORD_W'(bus.os_sel - 4'd1);
    assign w_send   = (r_state == c_ST_SEND);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_state    <= c_ST_IDLE;
            r_mask     <= '0;
            r_idx      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_idx      <= w_idx_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mask_nxt     = r_mask;
        w_idx_nxt      = r_idx;
        w_overflow_nxt = r_overflow;
        w_cap          = 1'b0;
        case (r_state)
            c_ST_IDLE, c_ST_CAPTURE: begin
                // A new header abandons any partial frame; a capture offered
                // in the same cycle belongs to the abandoned frame.
                if (bus.end_os) begin
                    w_state_nxt    = c_ST_IDLE;
                    w_mask_nxt     = '0;
                    w_overflow_nxt = 1'b0;
                end else if (w_sel_ok) begin
                    w_cap                = 1'b1;
                    w_mask_nxt[w_wr_idx] = 1'b1;
                    // Only the final code starts the drain; earlier gaps
                    // simply leave stale entries in the buffer.
                    if (bus.os_sel == c_SEL_MAX) begin
                        w_state_nxt = c_ST_SEND;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = c_ST_CAPTURE;
                    end
                end
            end
            c_ST_SEND: begin
                // The buffer is being read out, so any result offered now
                // is lost; end_os only clears status, the frame finishes.
                if (bus.os_sel != 4'd0) begin
                    w_overflow_nxt = 1'b1;
                end
                if (bus.end_os) begin
                    w_overflow_nxt = 1'b0;
                end
                if (bus.out_ready) begin
                    if (r_idx == c_LAST_IDX) begin
                        w_state_nxt = c_ST_IDLE;
                        w_mask_nxt  = '0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_mask_nxt  = '0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Result storage carries no reset; it is only read after a capture.
    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_buf[w_wr_idx] <= bus.os_data;
        end
    end

    // Byte index -> (result, lane), lane 0 being the most significant byte.
    always_comb begin
        w_word_idx = c_WORD_W'(int'(r_idx) / c_BPR);
        w_word     = r_buf[w_word_idx] >> (8 * (c_BPR - 1 - (int'(r_idx) % c_BPR)));
    end

    // Outputs decode registered state only, so they stay stable under
    // backpressure and fall immediately with the asynchronous reset.
    assign bus.out_valid = w_send;
    assign bus.out_byte  = w_send ? w_word[7:0] : 8'd0;
    assign bus.out_last  = w_send && (r_idx == c_LAST_IDX);
    assign bus.busy      = (r_state != c_ST_IDLE);
    assign bus.overflow  = r_overflow;
endmodule
`default_nettype wire

// File: tb/tb_os_result_drain.sv
`default_nettype none
// ============================================================================
// Module   : tb_os_result_drain
// Purpose  : Directed sequence with random result data and random sink
//            backpressure; expected bytes come from a result-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_os_result_drain;
    localparam int DATA_W  = 16;
    localparam int NUM_RES = 9;
    localparam int BPR     = DATA_W / 8;
    localparam int NBYTES  = NUM_RES * BPR;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Model: what each buffer slot should hold
    logic [DATA_W-1:0] ref_buf [NUM_RES];

    os_result_drain_if #(.DATA_W(DATA_W)) bus ();

    os_result_drain #(
        .DATA_W  (DATA_W),
        .NUM_RES (NUM_RES)
    ) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame byte i: result i/BPR, most significant byte first.
    function automatic logic [7:0] exp_byte(input int i);
        logic [DATA_W-1:0] w;
        w = ref_buf[i / BPR] >> (8 * (BPR - 1 - (i % BPR)));
        return w[7:0];
    endfunction

    // Present one select code for one cycle (only used when capture is legal).
    task automatic cap(input int sel, input logic [DATA_W-1:0] d);
        bus.os_sel  = 4'(sel);
        bus.os_data = d;
        tick();
        if (sel >= 1 && sel <= NUM_RES) ref_buf[sel-1] = d;
        bus.os_sel  = 4'd0;
    endtask

    task automatic fill_random();
        for (int k = 1; k <= NUM_RES; k++) cap(k, DATA_W'($urandom));
    endtask

    // Drain one frame. mode 0: ready high, 1: pattern 1,0,0,1, 2: random.
    // ovf_at / eos_at: cycle at which to offer os_sel=2 / pulse end_os.
    task automatic recv_frame(input int mode, input int ovf_at, input int eos_at);
        int   k;
        int   cyc;
        logic rdy;
        k   = 0;
        cyc = 0;
        while (k < NBYTES && cyc < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            bus.out_ready = rdy;
            bus.os_sel    = (cyc == ovf_at) ? 4'd2 : 4'd0;
            bus.os_data   = (cyc == ovf_at) ? 16'hFFFF : 16'h0000;
            bus.end_os    = (cyc == eos_at);
            chk("send_valid", 32'(bus.out_valid), 32'd1);
            chk("send_byte",  32'(bus.out_byte),  32'(exp_byte(k)));
            chk("send_last",  32'(bus.out_last),  32'(k == NBYTES - 1));
            chk("send_busy",  32'(bus.busy),      32'd1);
            tick();
            if (rdy) k++;
            bus.os_sel = 4'd0;
            bus.end_os = 1'b0;
            if (cyc == ovf_at) chk("ovf_set_send", 32'(bus.overflow), 32'd1);
            if (cyc == eos_at) chk("ovf_clr_send", 32'(bus.overflow), 32'd0);
            cyc++;
        end
        chk("frame_bytes", 32'(k), 32'(NBYTES));
        if (mode == 0) chk("frame_cycles", 32'(cyc), 32'(NBYTES));
        bus.out_ready = 1'b0;
        chk("after_valid", 32'(bus.out_valid), 32'd0);
        chk("after_busy",  32'(bus.busy),      32'd0);
        chk("after_last",  32'(bus.out_last),  32'd0);
    endtask

    initial begin
        rst           = 1'b1;
        bus.os_sel    = 4'd0;
        bus.os_data   = '0;
        bus.end_os    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid",    32'(bus.out_valid), 32'd0);
        chk("rst_busy",     32'(bus.busy),      32'd0);
        chk("rst_overflow", 32'(bus.overflow),  32'd0);
        chk("rst_last",     32'(bus.out_last),  32'd0);
        chk("rst_byte",     32'(bus.out_byte),  32'd0);
        rst = 1'b0;
        tick();

        // Reference frame 0101*k, ready held high
        for (int k = 1; k <= NUM_RES; k++) begin
            cap(k, DATA_W'(k * 16'h0101));
            if (k == 1) chk("capture_busy", 32'(bus.busy), 32'd1);
        end
        recv_frame(0, -1, -1);

        // Same frame under 1,0,0,1 backpressure
        for (int k = 1; k <= NUM_RES; k++) cap(k, DATA_W'(k * 16'h0101));
        recv_frame(1, -1, -1);

        // Overwrite of a slot and out-of-order arrival; last write wins
        cap(3, 16'hAAAA);
        cap(3, 16'h1234);
        for (int k = 1; k <= NUM_RES; k++) if (k != 3) cap(k, DATA_W'($urandom));
        recv_frame(2, -1, -1);

        // Overflow during SEND, cleared by end_os while still sending
        fill_random();
        recv_frame(0, 3, 10);

        // Overflow sticky into IDLE, cleared by end_os there
        fill_random();
        recv_frame(0, 2, -1);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);
        tick();
        chk("ovf_sticky2", 32'(bus.overflow), 32'd1);
        bus.end_os = 1'b1;
        tick();
        bus.end_os = 1'b0;
        chk("ovf_clr_idle", 32'(bus.overflow), 32'd0);

        // Out-of-range code in IDLE is ignored
        cap(12, DATA_W'($urandom));
        chk("oor_busy",     32'(bus.busy),     32'd0);
        chk("oor_overflow", 32'(bus.overflow), 32'd0);

        // Abort a partial frame; the capture offered with end_os is dropped
        for (int k = 1; k <= 4; k++) cap(k, DATA_W'($urandom));
        chk("partial_busy", 32'(bus.busy), 32'd1);
        bus.end_os    = 1'b1;
        bus.os_sel    = 4'd5;
        bus.os_data   = DATA_W'($urandom);
        tick();
        bus.end_os    = 1'b0;
        bus.os_sel    = 4'd0;
        bus.out_ready = 1'b1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;

        // Single-entry frame: final code alone sends, stale slots included
        cap(NUM_RES, DATA_W'($urandom));
        recv_frame(0, -1, -1);

        // Fresh full frame with random backpressure
        fill_random();
        recv_frame(2, -1, -1);

        // Asynchronous reset while byte 7 is on the bus
        fill_random();
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = 1'b1;
            bus.os_sel    = (i == 2) ? 4'd3 : 4'd0;
            chk("pre_rst_byte", 32'(bus.out_byte), 32'(exp_byte(i)));
            tick();
        end
        bus.os_sel = 4'd0;
        chk("pre_rst_ovf",   32'(bus.overflow),  32'd1);
        chk("pre_rst_byte7", 32'(bus.out_byte),  32'(exp_byte(7)));
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid",    32'(bus.out_valid), 32'd0);
        chk("arst_busy",     32'(bus.busy),      32'd0);
        chk("arst_overflow", 32'(bus.overflow),  32'd0);
        chk("arst_last",     32'(bus.out_last),  32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
            chk("post_rst_busy",  32'(bus.busy),      32'd0);
        end
        bus.out_ready = 1'b0;

        // Block recovers and drains a new frame
        fill_random();
        recv_frame(2, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
